laser_pulse_sequencer: RTL

//  Generates programmable laser/AOM gate pulse trains (on time, off time, repeat count) for

---
 rtl/laser_seq_pkg.sv | 16 +
 rtl/seq_down_counter.sv | 27 ++
 rtl/laser_pulse_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/laser_seq_pkg.sv
// Shared types and defaults for the laser pulse sequencer.
package laser_seq_pkg;

    localparam int unsigned CNT_W_DEF = 24;
    localparam int unsigned REP_W_DEF = 16;

    localparam logic [REP_W_DEF-1:0] IDX_ZERO = '0;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StFault
    } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter shared by the ON and OFF phases; parks at zero.
module seq_down_counter #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/laser_pulse_sequencer.sv
// Programmable on/off/repeat gate pulse train with interlock kill and abort.
module laser_pulse_sequencer
    import laser_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] on_cycles,
    input  logic [CNT_W-1:0] off_cycles,
    input  logic [REP_W-1:0] repeats,
    input  logic             interlock,
    output logic             laser,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [REP_W-1:0] pulse_idx
);

    seq_state_e state_q, state_d;

    logic [CNT_W-1:0] on_q, off_q;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] pulse_idx_q;
    logic             done_q;
    logic             fault_q;

    logic             accept;
    logic             degenerate;
    logic             last_pulse;
    logic             cnt_zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             idx_inc;
    logic             finish;
    logic             trip;
    logic             laser_q;

    assign accept     = start & ~abort & ~interlock &
                        ((state_q == StIdle) || (state_q == StFault));
    assign degenerate = (on_cycles == '0) || (repeats == '0);
    assign last_pulse = (pulse_idx_q == rep_q - REP_W'(1));

    seq_down_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_val),
        .en      (busy),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority in a running train: interlock, then abort, then phase expiry.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        idx_inc  = 1'b0;
        finish   = 1'b0;
        trip     = 1'b0;
        unique case (state_q)
            StIdle, StFault: begin
                if (accept) begin
                    if (!degenerate) begin
                        state_d  = StOn;
                        cnt_load = 1'b1;
                        cnt_val  = on_cycles - CNT_W'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end else if ((state_q == StFault) && !interlock) begin
                    state_d = StIdle;
                end
            end
            StOn: begin
                if (interlock) begin
                    state_d = StFault;
                    trip    = 1'b1;
                end else if (abort) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    if (last_pulse) begin
                        state_d = StIdle;
                        finish  = 1'b1;
                    end else if (off_q == '0) begin
                        state_d  = StOn;
                        cnt_load = 1'b1;
                        cnt_val  = on_q - CNT_W'(1);
                        idx_inc  = 1'b1;
                    end else begin
                        state_d  = StOff;
                        cnt_load = 1'b1;
                        cnt_val  = off_q - CNT_W'(1);
                    end
                end
            end
            StOff: begin
                if (interlock) begin
                    state_d = StFault;
                    trip    = 1'b1;
                end else if (abort) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d  = StOn;
                    cnt_load = 1'b1;
                    cnt_val  = on_q - CNT_W'(1);
                    idx_inc  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            on_q        <= '0;
            off_q       <= '0;
            rep_q       <= '0;
            pulse_idx_q <= REP_W'(IDX_ZERO);
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q <= finish | (accept & degenerate);
            if (accept) begin
                on_q        <= on_cycles;
                off_q       <= off_cycles;
                rep_q       <= repeats;
                pulse_idx_q <= REP_W'(IDX_ZERO);
                fault_q     <= 1'b0;
            end else begin
                if (idx_inc) begin
                    pulse_idx_q <= pulse_idx_q + REP_W'(1);
                end
                if (trip) begin
                    fault_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        laser_q   = (state_q == StOn);
        busy      = (state_q == StOn) || (state_q == StOff);
        laser     = laser_q & ~interlock;
        done      = done_q;
        fault     = fault_q;
        pulse_idx = pulse_idx_q;
    end

endmodule
